// File: rtl/aidc_path_ctrl.sv
// Purpose : sequences a glitch-free swap between the compression and bypass datapaths.
//           It stalls new AR/AW requests and waits until every outstanding read and
//           write has completed before it changes ENABLE.
// Latency : an idle switch stalls for 2 cycles. The stall rises one edge after the
//           request is sampled, and enable_o changes on the edge after that.
// Backpr. : only AR/AW are stalled (ar_stall_o/aw_stall_o). R and B are never stalled.
//
// Ports   : clk, rst_n (async, active low)
//           enable_req_i                requested path (1 = compression, 0 = bypass)
//           ar/aw_valid_i, ar/aw_ready_i    request handshakes, observed after gating
//           r_valid_i, r_ready_i, r_last_i  read completion (last beat)
//           b_valid_i, b_ready_i            write completion
//           enable_o, ar_stall_o, aw_stall_o, busy_o, rd_ot_o, wr_ot_o, err_o, timeout_o
// Options : when AIDC_PATH_CTRL_TIMEOUT_EN is defined, a drain that lasts TIMEOUT_CYC
//           cycles is abandoned and timeout_o is set. Otherwise timeout_o is tied to 0.
module aidc_path_ctrl #(
    parameter int OT_W        = 6,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable_req_i,
    input  logic            ar_valid_i,
    input  logic            ar_ready_i,
    input  logic            aw_valid_i,
    input  logic            aw_ready_i,
    input  logic            r_valid_i,
    input  logic            r_ready_i,
    input  logic            r_last_i,
    input  logic            b_valid_i,
    input  logic            b_ready_i,
    output logic            enable_o,
    output logic            ar_stall_o,
    output logic            aw_stall_o,
    output logic            busy_o,
    output logic [OT_W-1:0] rd_ot_o,
    output logic [OT_W-1:0] wr_ot_o,
    output logic            err_o,
    output logic            timeout_o
);

    typedef enum logic [1:0] {
        ST_STEADY = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    localparam logic [OT_W-1:0] OT_MAX = '1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_enable;
    logic            w_enable_nxt;
    logic [OT_W-1:0] r_rd_ot;
    logic [OT_W-1:0] r_wr_ot;
    logic [OT_W-1:0] w_rd_ot_nxt;
    logic [OT_W-1:0] w_wr_ot_nxt;
    logic            w_rd_err;
    logic            w_wr_err;
    logic            r_err;
    logic            w_to_hit;
    logic            w_to_fire;

    logic w_ar_hs;
    logic w_aw_hs;
    logic w_rl_hs;
    logic w_b_hs;
    logic w_ar_stall;
    logic w_aw_stall;

    assign w_ar_hs = ar_valid_i & ar_ready_i;
    assign w_aw_hs = aw_valid_i & aw_ready_i;
    assign w_rl_hs = r_valid_i & r_ready_i & r_last_i;
    assign w_b_hs  = b_valid_i & b_ready_i;

    // A saturated counter also stalls, so no further request can overflow it.
    assign w_ar_stall = (r_state != ST_STEADY) || (r_rd_ot == OT_MAX);
    assign w_aw_stall = (r_state != ST_STEADY) || (r_wr_ot == OT_MAX);

    // Outstanding counters. A request and a completion in the same cycle cancel.
    // An underflow or overflow holds the counter and is reported as a protocol error.
    always_comb begin
        w_rd_ot_nxt = r_rd_ot;
        w_rd_err    = 1'b0;
        if (w_ar_hs && !w_rl_hs) begin
            if (r_rd_ot == OT_MAX) w_rd_err = 1'b1;
            else                   w_rd_ot_nxt = r_rd_ot + 1'b1;
        end else if (w_rl_hs && !w_ar_hs) begin
            if (r_rd_ot == '0) w_rd_err = 1'b1;
            else               w_rd_ot_nxt = r_rd_ot - 1'b1;
        end
    end

    always_comb begin
        w_wr_ot_nxt = r_wr_ot;
        w_wr_err    = 1'b0;
        if (w_aw_hs && !w_b_hs) begin
            if (r_wr_ot == OT_MAX) w_wr_err = 1'b1;
            else                   w_wr_ot_nxt = r_wr_ot + 1'b1;
        end else if (w_b_hs && !w_aw_hs) begin
            if (r_wr_ot == '0) w_wr_err = 1'b1;
            else               w_wr_ot_nxt = r_wr_ot - 1'b1;
        end
    end

`ifdef AIDC_PATH_CTRL_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout;

    // The counter is held at zero outside DRAIN, so it always starts from zero on entry.
    // It reaches TIMEOUT_CYC-1 on the last permitted DRAIN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_to_cnt <= '0;
        else if (r_state != ST_DRAIN)  r_to_cnt <= '0;
        else if (!w_to_hit)            r_to_cnt <= r_to_cnt + 1'b1;
    end

    assign w_to_hit = (r_state == ST_DRAIN) && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_timeout <= 1'b0;
        else if (w_to_fire) r_timeout <= 1'b1;
    end

    assign timeout_o = r_timeout;
`else
    // TIMEOUT_CYC only matters in the timeout build; this term is always 0.
    assign w_to_hit  = 1'b0 & (TIMEOUT_CYC > 0);
    assign timeout_o = 1'b0;
`endif

    // The FSM uses registered counters. The switch is taken only after the last
    // completion has already been counted.
    always_comb begin
        w_state_nxt  = r_state;
        w_enable_nxt = r_enable;
        w_to_fire    = 1'b0;
        case (r_state)
            ST_STEADY: begin
                if (enable_req_i != r_enable) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (enable_req_i == r_enable) begin
                    w_state_nxt = ST_STEADY;
                end else if ((r_rd_ot == '0) && (r_wr_ot == '0)) begin
                    w_state_nxt  = ST_SWITCH;
                    w_enable_nxt = enable_req_i;
                end else if (w_to_hit) begin
                    w_state_nxt = ST_STEADY;
                    w_to_fire   = 1'b1;
                end
            end
            ST_SWITCH: w_state_nxt = ST_STEADY;
            default:   w_state_nxt = ST_STEADY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_STEADY;
            r_enable <= 1'b0;
            r_rd_ot  <= '0;
            r_wr_ot  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_enable <= w_enable_nxt;
            r_rd_ot  <= w_rd_ot_nxt;
            r_wr_ot  <= w_wr_ot_nxt;
            r_err    <= r_err | w_rd_err | w_wr_err
                        | (w_ar_hs & w_ar_stall) | (w_aw_hs & w_aw_stall);
        end
    end

    assign enable_o   = r_enable;
    assign ar_stall_o = w_ar_stall;
    assign aw_stall_o = w_aw_stall;
    assign busy_o     = (r_state != ST_STEADY);
    assign rd_ot_o    = r_rd_ot;
    assign wr_ot_o    = r_wr_ot;
    assign err_o      = r_err;

endmodule
